lut_frame_config_loader: RTL and testbench



---
 rtl/lut_cfg_pkg.sv | 32 +++
 rtl/lut_cfg_strobe_decoder.sv | 30 +++
 rtl/lut_frame_config_loader.sv | 149 ++++++++++++++
 tb/tb_lut_frame_config_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the LUT4AB frame configuration path: loader state
// encoding, header layout and the default column geometry that the tile
// generator also consumes.
package lut_cfg_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD
    } cfg_state_e;

    // Header word layout
    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         HDR_MAGIC_MSB = 31;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_COUNT_MSB = 15;
    localparam int         HDR_COUNT_LSB = 8;
    localparam int         HDR_START_LSB = 0;

    // Default frame geometry of one LUT4AB tile column
    localparam int DEF_FRAME_BITS_PER_ROW  = 32;
    localparam int DEF_MAX_FRAMES_PER_COL  = 20;
    localparam int DEF_FRAME_SELECT_WIDTH  = 5;
    localparam int DEF_STROBE_LEN          = 1;

    // Width of the per-frame strobe-cycle counter (StrobeLen is 1..15)
    localparam int STROBE_CNT_W = 4;

endpackage

// File: rtl/lut_cfg_strobe_decoder.sv
// Registered one-hot decoder driving the tile's frame strobe lines. The output
// register guarantees glitch-free strobes; with enable low every line is zero.
module lut_cfg_strobe_decoder #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [FrameSelectWidth-1:0] cur_idx,
    output logic [MaxFramesPerCol-1:0]  frame_strobe
);

    logic [MaxFramesPerCol-1:0] onehot;

    // One compare per strobe line; an out-of-range index decodes to no line
    for (genvar g = 0; g < MaxFramesPerCol; g++) begin : g_line
        assign onehot[g] = enable && (cur_idx == FrameSelectWidth'(g));
    end

    // Register the decoded strobe so the tile sees clean edges
    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_strobe <= '0;
        end else begin
            frame_strobe <= onehot;
        end
    end

endmodule

// File: rtl/lut_frame_config_loader.sv
// Frame configuration loader for a LUT4AB tile column. Takes a header word
// (magic, frame count, start index) followed by one data word per frame and
// writes each frame with a setup / strobe / hold sequence.
module lut_frame_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow  = DEF_FRAME_BITS_PER_ROW,
    parameter int MaxFramesPerCol  = DEF_MAX_FRAMES_PER_COL,
    parameter int FrameSelectWidth = DEF_FRAME_SELECT_WIDTH,
    parameter int StrobeLen        = DEF_STROBE_LEN
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       abort,
    output logic [FrameBitsPerRow-1:0] frame_data,
    output logic [MaxFramesPerCol-1:0] frame_strobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    // Start + count is summed wide enough that an 8-bit count on top of the
    // largest start index can never wrap past the column size.
    localparam int CheckW = FrameSelectWidth + 9;

    cfg_state_e                  state_q, state_d;
    logic [FrameSelectWidth-1:0] cur_idx_q;
    logic [7:0]                  remaining_q;
    logic [STROBE_CNT_W-1:0]     strobe_cnt_q;
    logic [FrameBitsPerRow-1:0]  frame_data_q;
    logic                        err_q;
    logic                        done_q;

    logic [7:0]                  hdr_magic;
    logic [7:0]                  hdr_count;
    logic [FrameSelectWidth-1:0] hdr_start;
    logic [CheckW-1:0]           hdr_end;
    logic                        hdr_good;
    logic                        xfer;
    logic                        last_strobe;
    logic                        last_frame;

    // Header field extraction and legality check
    assign hdr_magic = s_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    assign hdr_count = s_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
    assign hdr_start = s_data[HDR_START_LSB +: FrameSelectWidth];
    assign hdr_end   = CheckW'(hdr_start) + CheckW'(hdr_count);
    assign hdr_good  = (hdr_magic == HDR_MAGIC) && (hdr_count != 8'd0) &&
                       (hdr_end <= CheckW'(MaxFramesPerCol));

    // Ready is a pure function of state (plus abort/reset), never of s_valid;
    // abort blocks a same-edge LOAD transfer.
    assign s_ready = !reset && !abort && ((state_q == IDLE) || (state_q == LOAD));
    assign xfer    = s_valid && s_ready;

    assign last_strobe = (strobe_cnt_q == STROBE_CNT_W'(StrobeLen - 1));
    assign last_frame  = (remaining_q == 8'd1);

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer && hdr_good) state_d = LOAD;
            LOAD:    if (xfer) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (last_strobe) state_d = HOLD;
            HOLD:    state_d = last_frame ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Datapath: header latch, frame data capture, strobe timing, frame counters
    always_ff @(posedge CLK) begin
        if (reset) begin
            cur_idx_q    <= '0;
            remaining_q  <= '0;
            strobe_cnt_q <= '0;
            frame_data_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_q == HOLD) && last_frame && !abort;

            if ((state_q == IDLE) && xfer) begin
                if (hdr_good) begin
                    cur_idx_q   <= hdr_start;
                    remaining_q <= hdr_count;
                    err_q       <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end

            // The only place frame_data changes, so it is stable SETUP..HOLD
            if ((state_q == LOAD) && xfer) begin
                frame_data_q <= s_data;
            end

            if (state_q == STROBE) begin
                strobe_cnt_q <= strobe_cnt_q + 1'b1;
            end else begin
                strobe_cnt_q <= '0;
            end

            // Advance after the hold cycle; the index is not bumped past the
            // final frame so it stays inside the column.
            if ((state_q == HOLD) && !abort) begin
                remaining_q <= remaining_q - 8'd1;
                if (!last_frame) begin
                    cur_idx_q <= cur_idx_q + 1'b1;
                end
            end
        end
    end

    // Strobe is registered from the next state, so it is high exactly while
    // the loader sits in STROBE and drops on the same edge an abort lands.
    lut_cfg_strobe_decoder #(
        .MaxFramesPerCol  (MaxFramesPerCol),
        .FrameSelectWidth (FrameSelectWidth)
    ) u_strobe_dec (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (state_d == STROBE),
        .cur_idx      (cur_idx_q),
        .frame_strobe (frame_strobe)
    );

    assign frame_data = frame_data_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lut_frame_config_loader.sv
// Bench for the frame loader: one instance with StrobeLen=1 and one with
// StrobeLen=4. Observed strobe writes are logged each cycle and compared with
// the frame list implied by each header and its data words.
module tb_lut_frame_config_loader;

    localparam int NF = 20;
    localparam int L1 = 1;
    localparam int L4 = 4;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   s_data1 = '0, s_data4 = '0;
    logic          s_valid1 = 1'b0, s_valid4 = 1'b0;
    logic          abort1 = 1'b0, abort4 = 1'b0;
    logic          s_ready1, s_ready4, busy1, busy4, done1, done4, err1, err4;
    logic [31:0]   frame_data1, frame_data4;
    logic [NF-1:0] frame_strobe1, frame_strobe4;

    int          checks = 0, errors = 0, cyc = 0;
    int          done_cnt1 = 0, done_cnt4 = 0, done_cyc1 = 0, done_cyc4 = 0, xfer_cyc = 0;
    logic [31:0] prev_fd1 = '0, prev_fd4 = '0;
    wr_t         log1[$], log4[$], exp_q[$];
    logic [31:0] words[$];

    always #5 CLK = ~CLK;

    lut_frame_config_loader #(.StrobeLen(L1)) u_dut1 (
        .CLK(CLK), .reset(reset), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .abort(abort1), .frame_data(frame_data1), .frame_strobe(frame_strobe1),
        .busy(busy1), .done(done1), .err(err1)
    );

    lut_frame_config_loader #(.StrobeLen(L4)) u_dut4 (
        .CLK(CLK), .reset(reset), .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4),
        .abort(abort4), .frame_data(frame_data4), .frame_strobe(frame_strobe4),
        .busy(busy4), .done(done4), .err(err4)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec model of a header: magic, at least one frame, fits in the column
    function automatic bit hdr_ok(input logic [31:0] h);
        int s, n;
        s = int'(h[4:0]);
        n = int'(h[15:8]);
        return (h[31:24] == 8'hA5) && (n >= 1) && (s + n <= NF);
    endfunction

    function automatic int idx_of(input logic [NF-1:0] v);
        int r;
        r = -1;
        for (int i = NF - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic mon_dut(input logic [NF-1:0] stb, input logic [31:0] fd, input logic rdy,
                           input logic bsy, input logic [31:0] pfd, output bit hit, output int idx);
        hit = (stb != '0);
        idx = -1;
        if (hit) begin
            chk("strobe_onehot", $countones(stb), 1);
            chk("strobe_state_rdy_busy", 32'({rdy, bsy}), 32'b01);
            chk("data_stable_in_strobe", fd, pfd);
            idx = idx_of(stb);
        end
    endtask

    task automatic monitor();
        bit hit;
        int idx;
        mon_dut(frame_strobe1, frame_data1, s_ready1, busy1, prev_fd1, hit, idx);
        if (hit) log1.push_back('{idx, frame_data1, cyc});
        if (done1) begin done_cnt1++; done_cyc1 = cyc; end
        prev_fd1 = frame_data1;
        mon_dut(frame_strobe4, frame_data4, s_ready4, busy4, prev_fd4, hit, idx);
        if (hit) log4.push_back('{idx, frame_data4, cyc});
        if (done4) begin done_cnt4++; done_cyc4 = cyc; end
        prev_fd4 = frame_data4;
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        monitor();
    endtask

    task automatic drive(input bit d4, input logic v, input logic [31:0] w);
        if (d4) begin s_valid4 = v; s_data4 = w; end
        else    begin s_valid1 = v; s_data1 = w; end
    endtask

    // Present one word, hold it until accepted, then drop valid
    task automatic send(input bit d4, input logic [31:0] w, input int max_gap);
        int budget, gap;
        if (max_gap > 0) begin
            gap = int'($urandom_range(max_gap, 0));
            drive(d4, 1'b0, $urandom);
            repeat (gap) tick();
        end
        drive(d4, 1'b1, w);
        #1;
        budget = 64;
        while (!(d4 ? s_ready4 : s_ready1) && budget > 0) begin
            tick();
            budget--;
        end
        chk("ready_wait", 32'(budget > 0), 1);
        tick();
        xfer_cyc = cyc;
        drive(d4, 1'b0, $urandom);
    endtask

    task automatic compare_log(input bit d4);
        int  n;
        wr_t o;
        n = d4 ? log4.size() : log1.size();
        chk("write_count", n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            o = d4 ? log4[i] : log1[i];
            chk("write_idx", o.idx, exp_q[i].idx);
            chk("write_data", o.data, exp_q[i].data);
        end
    endtask

    // Full transaction: header, data words (from 'words' or random), wait for done
    task automatic burst(input bit d4, input logic [31:0] hdr, input int max_gap);
        int          s, n, len, d0, x0;
        logic [31:0] w;
        wr_t         a, b;
        len = d4 ? L4 : L1;
        s = int'(hdr[4:0]);
        n = int'(hdr[15:8]);
        exp_q.delete();
        if (d4) log4.delete(); else log1.delete();
        d0 = d4 ? done_cnt4 : done_cnt1;
        send(d4, hdr, max_gap);
        chk("hdr_err", 32'(d4 ? err4 : err1), 32'(!hdr_ok(hdr)));
        if (hdr_ok(hdr)) begin
            for (int k = 0; k < n; k++) begin
                w = (words.size() > 0) ? words.pop_front() : $urandom;
                send(d4, w, max_gap);
                chk("data_in_setup", d4 ? frame_data4 : frame_data1, w);
                chk("strobe_low_in_setup", 32'(d4 ? frame_strobe4 : frame_strobe1), 0);
                for (int r = 0; r < len; r++) exp_q.push_back('{s + k, w, 0});
            end
            x0 = xfer_cyc;
            for (int t = 0; t < 30 && (d4 ? done_cnt4 : done_cnt1) == d0; t++) tick();
            chk("done_latency", d4 ? done_cyc4 : done_cyc1, x0 + 2 + len);
            chk("busy_after_done", 32'(d4 ? busy4 : busy1), 0);
        end else begin
            chk("bad_hdr_idle", 32'(d4 ? busy4 : busy1), 0);
        end
        tick();
        tick();
        chk("done_pulses", (d4 ? done_cnt4 : done_cnt1) - d0, hdr_ok(hdr) ? 1 : 0);
        compare_log(d4);
        if (max_gap == 0 && (d4 ? log4.size() : log1.size()) == exp_q.size()) begin
            for (int i = len; i < exp_q.size(); i += len) begin
                a = d4 ? log4[i] : log1[i];
                b = d4 ? log4[i - len] : log1[i - len];
                chk("strobe_spacing", a.cyc - b.cyc, 3 + len);
            end
        end
    endtask

    initial begin
        int          s, n, d0;
        logic [31:0] h, fd_before;

        // Reset state
        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_frame_data", frame_data1, 0);
        chk("rst_strobe", 32'(frame_strobe1), 0);
        chk("rst_strobe4", 32'(frame_strobe4), 0);
        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(s_ready1), 1);

        // Single frame N=1 S=3
        words.push_back(32'h0001_FFFF);
        burst(1'b0, 32'hA500_0103, 0);
        if (log1.size() > 0) chk("single_strobe_cycle", log1[0].cyc, xfer_cyc + 1);

        // Burst N=3 S=17
        words.push_back(32'h11);
        words.push_back(32'h22);
        words.push_back(32'h33);
        burst(1'b0, 32'hA500_0311, 0);

        // Bad headers, then a good one clears err
        burst(1'b0, 32'h5A00_0100, 0);
        burst(1'b0, 32'hA500_0003, 0);
        burst(1'b0, 32'hA500_0412, 0);
        chk("err_sticky", 32'(err1), 1);
        burst(1'b0, 32'hA500_0200, 0);
        chk("err_cleared", 32'(err1), 0);

        // StrobeLen=4: abort in the second strobe cycle
        log4.delete();
        d0 = done_cnt4;
        send(1'b1, 32'hA500_0302, 0);
        send(1'b1, 32'hDEAD_0001, 0);
        for (int t = 0; t < 10 && frame_strobe4 == '0; t++) tick();
        tick();
        chk("abort_pre_strobe", 32'(frame_strobe4), 32'h4);
        abort4 = 1'b1;
        #1;
        chk("abort_ready_low", 32'(s_ready4), 0);
        tick();
        abort4 = 1'b0;
        chk("abort_strobe_off", 32'(frame_strobe4), 0);
        chk("abort_busy_off", 32'(busy4), 0);
        chk("abort_err_kept", 32'(err4), 0);
        chk("abort_strobe_cycles", log4.size(), 2);
        tick();
        chk("abort_no_done", done_cnt4 - d0, 0);
        burst(1'b1, 32'hA500_0205, 0);

        // Abort while in LOAD with a word on the bus: word must not load
        send(1'b1, 32'hA500_0105, 0);
        fd_before = frame_data4;
        abort4 = 1'b1;
        drive(1'b1, 1'b1, 32'hBAD0_BAD0);
        #1;
        chk("abort_load_ready", 32'(s_ready4), 0);
        tick();
        abort4 = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        chk("abort_load_idle", 32'(busy4), 0);
        chk("abort_load_data", frame_data4, fd_before);
        burst(1'b1, 32'hA500_0110, 0);

        // Backpressure: five frames with random valid gaps
        s = int'($urandom_range(15, 0));
        burst(1'b0, 32'hA500_0500 | 32'(s), 2);

        // Randomized headers, good and bad, with random gaps
        for (int it = 0; it < 10; it++) begin
            s = int'($urandom_range(19, 0));
            n = int'($urandom_range(NF - s, 1));
            h = {8'hA5, 8'($urandom), 8'(n), 3'($urandom), 5'(s)};
            case ($urandom_range(5, 0))
                0:       h[31:24] = 8'h5A;
                1:       h[15:8]  = 8'h00;
                2:       h[15:8]  = 8'(NF + 1 - s);
                default: ;
            endcase
            burst(1'b0, h, int'($urandom_range(2, 0)));
        end

        // Reset during HOLD
        burst(1'b1, 32'h0000_0000, 0);
        chk("pre_reset_err4", 32'(err4), 1);
        log1.delete();
        send(1'b0, 32'hA500_0200, 0);
        send(1'b0, 32'hCAFE_0001, 0);
        for (int t = 0; t < 10 && frame_strobe1 == '0; t++) tick();
        tick();
        chk("hold_busy", 32'(busy1), 1);
        chk("hold_strobe_low", 32'(frame_strobe1), 0);
        reset = 1'b1;
        #1;
        chk("reset_ready_low", 32'(s_ready1), 0);
        tick();
        chk("mid_reset_fd", frame_data1, 0);
        chk("mid_reset_strobe", 32'(frame_strobe1), 0);
        chk("mid_reset_busy", 32'(busy1), 0);
        chk("mid_reset_done", 32'(done1), 0);
        chk("mid_reset_err4", 32'(err4), 0);
        chk("mid_reset_writes", log1.size(), 1);
        reset = 1'b0;
        burst(1'b0, 32'hA500_0400 | 32'($urandom_range(16, 0)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
